// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 serial receiver with 16x oversampling. It presents each received byte
// on a valid/ready output.
//
// Ports
//   clk        : single clock. All logic runs on its rising edge.
//   areset_n   : asynchronous active-low reset. It is released synchronously
//                to clk.
//   rx_i       : serial line. It is asynchronous to clk and idles high.
//   rx_data    : received byte. It is valid while rx_valid is high.
//   rx_valid   : a byte is available.
//   rx_ready   : the consumer takes the byte in any cycle where
//                rx_valid & rx_ready.
//   frame_err  : one-clock pulse when the stop bit is sampled low.
//   overrun    : one-clock pulse when a completed byte is dropped.
//   dbg_state  : current FSM state (0=IDLE 1=START 2=DATA 3=STOP 4=BRK).
//
// Handshake: rx_valid rises with rx_data, and rx_data stays unchanged until
// the cycle where rx_valid & rx_ready. rx_ready has no effect while rx_valid
// is low.
module uart_rx_core #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    sc_q, sc_d;
  logic [2:0]    bc_q, bc_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          deliver_q, deliver_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rxs;
  logic          tick;

  assign rxs  = sync2_q;
  assign tick = (div_cnt_q == CW'(DIV - 1));

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  // The receive FSM only advances on oversample ticks. sc counts ticks
  // within a bit. START waits 8 ticks to reach the middle of the start bit.
  // After that, each 16-tick period ends at the middle of the next bit.
  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    bc_d        = bc_q;
    shreg_d     = shreg_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            sc_d    = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (sc_q == 4'd7) begin
            if (!rxs) begin
              sc_d    = '0;
              bc_d    = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        S_DATA: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shreg_d = {rxs, shreg_q[7:1]};
            bc_d    = bc_q + 3'd1;
            if (bc_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            if (rxs) begin
              deliver_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BRK;
            end
          end
        end
        S_BRK: begin
          // Wait here while the line is held low so that a break cannot
          // look like a new start bit.
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Delivery takes place one clock after the stop-bit tick. A consumer that
  // accepts in that same cycle frees the slot for the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (deliver_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      div_cnt_q   <= '0;
      sc_q        <= '0;
      bc_q        <= '0;
      shreg_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      div_cnt_q   <= div_cnt_d;
      sc_q        <= sc_d;
      bc_q        <= bc_d;
      shreg_q     <= shreg_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit (DIV=1).
module tb_uart_rx_core;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BIG    = 1 << 30;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       rx_i = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .rx_i      (rx_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int hs_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vhi_cnt = 0;
  logic [7:0] exp_q[$];
  int hs_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every accepted byte is compared against the oldest expected one
  always @(negedge clk) begin
    if (areset_n) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid) vhi_cnt++;
      if (rx_valid && rx_ready) begin
        hs_cnt++;
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_byte: observed=0x%0h expected=none", rx_data);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver: start bit, 8 data bits LSB first, stop bit; abort (line high) after max_clks
  task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit,
                            input int max_clks);
    logic [9:0] bits;
    int n;
    bits = {stop_bit, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < per; k++) begin
        @(posedge clk);
        #1;
        if (n == max_clks) begin
          rx_i = 1'b1;
          return;
        end
        if (i == 0 && k == 0) start_cyc = cyc;
        rx_i = bits[i];
        n++;
      end
    end
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("hs_timeout", {31'd0, hs_cnt >= target}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int h0, fe0, ov0, v0;
  logic [7:0] b2b[4];

  initial begin
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'hAA;

    // reset state
    idle(3);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    areset_n = 1'b1;
    idle(10);
    check("idle_flags", {30'd0, frame_err, overrun}, 32'd0);

    // reset 40 clocks into 0xA5
    h0 = hs_cnt;
    send_frame(8'hA5, 16, 1'b1, 40);
    check("mid_state", {29'd0, dbg_state}, 32'd2);
    areset_n = 1'b0;
    #1;
    check("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    check("mid_rst_out", {21'd0, rx_data, rx_valid, frame_err, overrun}, 32'd0);
    idle(3);
    areset_n = 1'b1;
    idle(200);
    check("mid_rst_nobyte", hs_cnt, h0);

    // clean 0x3C: latency and 1-clock valid pulse
    exp_q.push_back(8'h3C);
    hs_cyc_q.delete();
    v0 = vhi_cnt;
    send_frame(8'h3C, 16, 1'b1, BIG);
    wait_hs(h0 + 1, 300);
    if (hs_cyc_q.size() > 0) check("latency", hs_cyc_q[0] - start_cyc, 32'd156);
    idle(5);
    check("valid_width", vhi_cnt - v0, 32'd1);

    // back-to-back
    h0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    hs_cyc_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(b2b[i]);
    for (int i = 0; i < 4; i++) send_frame(b2b[i], 16, 1'b1, BIG);
    wait_hs(h0 + 4, 300);
    for (int i = 1; i < 4; i++)
      if (hs_cyc_q.size() > i) check("b2b_spacing", hs_cyc_q[i] - hs_cyc_q[i-1], 32'd160);
    check("b2b_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

    // false start
    idle(20);
    h0 = hs_cnt; fe0 = fe_cnt;
    rx_i = 1'b0;
    idle(5);
    rx_i = 1'b1;
    idle(40);
    check("glitch_state", {29'd0, dbg_state}, 32'd0);
    check("glitch_nobyte", hs_cnt, h0);
    check("glitch_nofe", fe_cnt, fe0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 16, 1'b1, BIG);
    wait_hs(h0 + 1, 300);

    // framing error then break
    idle(20);
    h0 = hs_cnt; fe0 = fe_cnt;
    send_frame(8'h42, 16, 1'b0, BIG);
    idle(50);
    check("brk_state", {29'd0, dbg_state}, 32'd4);
    check("fe_pulse", fe_cnt - fe0, 32'd1);
    rx_i = 1'b1;
    idle(20);
    check("brk_exit", {29'd0, dbg_state}, 32'd0);
    check("fe_nobyte", hs_cnt, h0);
    exp_q.push_back(8'h24);
    send_frame(8'h24, 16, 1'b1, BIG);
    wait_hs(h0 + 1, 300);

    // backpressure and overrun
    idle(20);
    rx_ready = 1'b0;
    h0 = hs_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 16, 1'b1, BIG);
    send_frame(8'h22, 16, 1'b1, BIG);
    idle(10);
    check("bp_valid", {31'd0, rx_valid}, 32'd1);
    check("bp_data", {24'd0, rx_data}, 32'h11);
    check("ov_pulse", ov_cnt - ov0, 32'd1);
    rx_ready = 1'b1;
    idle(1);
    check("bp_consumed", {31'd0, rx_valid}, 32'd0);
    check("bp_hs", hs_cnt, h0 + 1);

    // accept in the same cycle the next byte loads
    idle(20);
    rx_ready = 1'b0;
    h0 = hs_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 16, 1'b1, BIG);
    idle(20);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 16, 1'b1, BIG);
      begin
        @(posedge clk);
        repeat (155) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        check("simul_valid", {31'd0, rx_valid}, 32'd1);
        check("simul_data", {24'd0, rx_data}, 32'h22);
      end
    join
    check("simul_no_ov", ov_cnt, ov0);
    rx_ready = 1'b1;
    wait_hs(h0 + 2, 20);

    // baud skew
    idle(20);
    h0 = hs_cnt;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 15, 1'b1, BIG);
    wait_hs(h0 + 1, 300);
    idle(20);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 17, 1'b1, BIG);
    wait_hs(h0 + 2, 300);

    idle(20);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("fe_total", fe_cnt, 32'd1);
    check("ov_total", ov_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
